hack_cpu_seq: RTL and testbench

- Multi-cycle Hack CPU sequencer that sits around the existing 16-bit Hack ALU (`my_alu`).
- Fetches instructions over an imem handshake and holds the A, D and PC registers.
- Decodes C-instructions into `zx/nx/zy/ny/f/no` for `my_alu` and feeds its `x`/`y` inputs.
- Consumes the ALU's `out`/`zr`/`ng` for writeback and jump resolution; M reads and writes go over a dmem handshake.

---
 rtl/hack_pkg.sv | 24 ++
 rtl/hack_cpu_seq_if.sv | 22 ++
 rtl/my_alu.sv | 28 ++
 rtl/hack_cpu_seq.sv | 109 ++++++++++
 tb/tb_hack_cpu_seq.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU sequencer: states, instruction fields, jump rule.
package hack_pkg;
  localparam int ADDR_W = 15;

  // C-instruction field positions
  localparam int A_BIT    = 12;
  localparam int COMP_MSB = 11;
  localparam int COMP_LSB = 6;
  localparam int DEST_A   = 5;
  localparam int DEST_D   = 4;
  localparam int DEST_M   = 3;
  localparam int JLT      = 2;
  localparam int JEQ      = 1;
  localparam int JGT      = 0;

  typedef enum logic [2:0] {
    BOOT, FETCH, DECODE, MREAD, EXEC, WB
  } state_t;

  // Jump bits 111 cover all three sign cases, so they always jump.
  function automatic logic jump_taken(input logic [2:0] j, input logic zr, input logic ng);
    return (j[JLT] & ng) | (j[JEQ] & zr) | (j[JGT] & ~ng & ~zr);
  endfunction
endpackage

// File: rtl/hack_cpu_seq_if.sv
// Instruction and data memory handshakes between the sequencer and its memories.
interface hack_cpu_seq_if #(parameter int ADDR_W = hack_pkg::ADDR_W);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [15:0]       imem_rdata;
  logic              dmem_rd;
  logic              dmem_wr;
  logic [ADDR_W-1:0] dmem_addr;
  logic [15:0]       dmem_wdata;
  logic              dmem_ack;
  logic [15:0]       dmem_rdata;

  modport master (
    output imem_req, imem_addr, dmem_rd, dmem_wr, dmem_addr, dmem_wdata,
    input  imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );
  modport slave (
    input  imem_req, imem_addr, dmem_rd, dmem_wr, dmem_addr, dmem_wdata,
    output imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/my_alu.sv
// 16-bit Hack ALU: optional zero/negate of each input, add or and, optional negate of result.
module my_alu (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng
);
  logic [15:0] xz, xn, yz, yn, r;

  // Pure combinational ALU datapath.
  always_comb begin
    xz  = zx ? 16'h0 : x;
    xn  = nx ? ~xz : xz;
    yz  = zy ? 16'h0 : y;
    yn  = ny ? ~yz : yz;
    r   = f ? (xn + yn) : (xn & yn);
    out = no ? ~r : r;
    zr  = (out == 16'h0);
    ng  = out[15];
  end
endmodule

// File: rtl/hack_cpu_seq.sv
// Multi-cycle Hack CPU sequencer around my_alu; fetch/M traffic via handshakes.
module hack_cpu_seq
  import hack_pkg::*;
#(
  parameter int                ADDR_W   = hack_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  hack_cpu_seq_if.master    bus,
  output logic [ADDR_W-1:0] pc_dbg
);
  state_t            state, state_n;
  logic [ADDR_W-1:0] pc;
  logic [15:0]       a_r, d_r, ir, mr, res;
  logic              zr_r, ng_r;
  logic [15:0]       alu_out;
  logic              alu_zr, alu_ng;
  logic              wb_done, take;
  logic              unused_bits;

  assign unused_bits   = &{1'b0, ir[14:13], a_r[15], res};
  assign pc_dbg        = pc;
  assign bus.imem_addr = pc;

  my_alu u_alu (
    .x  (d_r),
    .y  (ir[A_BIT] ? mr : a_r),
    .zx (ir[COMP_MSB]),
    .nx (ir[COMP_MSB-1]),
    .zy (ir[COMP_MSB-2]),
    .ny (ir[COMP_MSB-3]),
    .f  (ir[COMP_LSB+1]),
    .no (ir[COMP_LSB]),
    .out(alu_out),
    .zr (alu_zr),
    .ng (alu_ng)
  );

  assign wb_done = (state == WB) && (!ir[DEST_M] || bus.dmem_ack);
  assign take    = jump_taken(ir[2:0], zr_r, ng_r);

  // Next-state decode; acks outside their owning state are ignored.
  always_comb begin
    state_n = state;
    case (state)
      BOOT:    state_n = FETCH;
      FETCH:   if (bus.imem_ack) state_n = DECODE;
      DECODE:  state_n = !ir[15] ? FETCH : (ir[A_BIT] ? MREAD : EXEC);
      MREAD:   if (bus.dmem_ack) state_n = EXEC;
      EXEC:    state_n = WB;
      WB:      if (wb_done) state_n = FETCH;
      default: state_n = BOOT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_n;
  end

  // Architectural registers and registered request strobes (driven from the next state
  // so a request is visible in the same cycle its state is entered).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc             <= RESET_PC;
      a_r            <= '0;
      d_r            <= '0;
      ir             <= '0;
      mr             <= '0;
      res            <= '0;
      zr_r           <= 1'b0;
      ng_r           <= 1'b0;
      bus.imem_req   <= 1'b0;
      bus.dmem_rd    <= 1'b0;
      bus.dmem_wr    <= 1'b0;
      bus.dmem_addr  <= '0;
      bus.dmem_wdata <= '0;
    end else begin
      bus.imem_req <= (state_n == FETCH);
      bus.dmem_rd  <= (state_n == MREAD);
      bus.dmem_wr  <= (state_n == WB) && ir[DEST_M];
      if (state == FETCH && bus.imem_ack) ir <= bus.imem_rdata;
      if (state == DECODE) begin
        if (!ir[15]) begin
          a_r <= ir;
          pc  <= pc + 1'b1;
        end else if (ir[A_BIT]) begin
          bus.dmem_addr <= a_r[ADDR_W-1:0];
        end
      end
      if (state == MREAD && bus.dmem_ack) mr <= bus.dmem_rdata;
      if (state == EXEC) begin
        res            <= alu_out;
        zr_r           <= alu_zr;
        ng_r           <= alu_ng;
        // Address taken before WB can touch A, so M and jump both see A_old.
        bus.dmem_addr  <= a_r[ADDR_W-1:0];
        bus.dmem_wdata <= alu_out;
      end
      if (wb_done) begin
        if (ir[DEST_A]) a_r <= bus.dmem_wdata;
        if (ir[DEST_D]) d_r <= bus.dmem_wdata;
        pc <= take ? a_r[ADDR_W-1:0] : pc + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_hack_cpu_seq.sv
// Directed bench for hack_cpu_seq: memories emulated by a task, expected values hand-computed.
module tb_hack_cpu_seq;
  logic        clk, rst_n;
  logic [14:0] pc_dbg;
  int          total, bad;
  int          cyc, hold_ok;
  bit          istable;
  logic [14:0] f_addr, m_addr, m_pc;
  logic [15:0] m_wdata;
  logic        m_wr, m_seen;

  hack_cpu_seq_if bus ();

  hack_cpu_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .pc_dbg(pc_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Run one instruction: answer the fetch after iw wait cycles, answer any M access after
  // dw wait cycles with rdata rd, return once the next fetch is requested.
  task automatic run(input logic [15:0] ins, input int iw, input int dw, input logic [15:0] rd,
                     output int c);
    int  n;
    bit  done;
    int  hold;
    n = 0;
    c = 0;
    while (!bus.imem_req && n < 50) begin @(negedge clk); n++; end
    if (!bus.imem_req) chk("fetch_timeout", 0, 1);
    f_addr  = bus.imem_addr;
    istable = 1'b1;
    for (int i = 0; i < iw; i++) begin
      @(negedge clk); c++;
      if (bus.imem_addr !== f_addr || bus.imem_req !== 1'b1) istable = 1'b0;
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = ins;
    @(negedge clk); c++;
    bus.imem_ack   = 1'b0;
    done    = 1'b0;
    m_seen  = 1'b0;
    hold_ok = 0;
    n       = 0;
    while (!done && n < 50) begin
      if (bus.imem_req) done = 1'b1;
      else if (bus.dmem_rd || bus.dmem_wr) begin
        m_seen  = 1'b1;
        m_addr  = bus.dmem_addr;
        m_wdata = bus.dmem_wdata;
        m_wr    = bus.dmem_wr;
        m_pc    = pc_dbg;
        hold    = 0;
        while ((bus.dmem_rd || bus.dmem_wr) && hold <= dw) begin
          if (bus.dmem_addr === m_addr && bus.dmem_wdata === m_wdata && pc_dbg === m_pc)
            hold_ok++;
          hold++;
          if (hold == dw + 1) begin
            bus.dmem_ack   = 1'b1;
            bus.dmem_rdata = rd;
          end
          @(negedge clk); c++;
          bus.dmem_ack = 1'b0;
        end
      end else begin
        @(negedge clk); c++; n++;
      end
    end
    if (!done) chk("exec_timeout", 0, 1);
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0;
    bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_imem_req", bus.imem_req, 0);
    chk("rst_pc", pc_dbg, 0);
    chk("rst_dmem_strb", {bus.dmem_rd, bus.dmem_wr}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("boot_req", bus.imem_req, 1);
    chk("boot_addr", bus.imem_addr, 0);
    chk("boot_dmem_strb", {bus.dmem_rd, bus.dmem_wr}, 0);

    // A-instruction, zero-wait then delayed fetch
    run(16'h0005, 0, 0, 0, cyc);
    chk("ainst_cyc", cyc, 2);
    chk("ainst_a", dut.a_r, 16'h0005);
    chk("ainst_pc", pc_dbg, 1);
    run(16'h0005, 4, 0, 0, cyc);
    chk("ainst_slow_stable", istable, 1);
    chk("ainst_slow_a", dut.a_r, 16'h0005);
    chk("ainst_slow_pc", pc_dbg, 2);

    // ALU path
    run(16'hEC10, 0, 0, 0, cyc);
    chk("d_eq_a", dut.d_r, 16'h0005);
    chk("cinst_cyc", cyc, 4);
    run(16'hE7D0, 0, 0, 0, cyc);
    chk("d_plus1", dut.d_r, 16'h0006);
    chk("d_plus1_pc", pc_dbg, 4);

    // M write with delayed ack
    run(16'h0064, 0, 0, 0, cyc);
    run(16'hE308, 0, 3, 0, cyc);
    chk("mwr_seen", {m_seen, m_wr}, 2'b11);
    chk("mwr_addr", m_addr, 100);
    chk("mwr_wdata", m_wdata, 6);
    chk("mwr_pc_hold", m_pc, 5);
    chk("mwr_hold", hold_ok, 4);
    chk("mwr_pc_after", pc_dbg, 6);

    // JGT taken
    run(16'h0005, 0, 0, 0, cyc);
    run(16'hEC10, 0, 0, 0, cyc);
    run(16'h0014, 0, 0, 0, cyc);
    run(16'hE301, 0, 0, 0, cyc);
    chk("jgt_taken", pc_dbg, 20);
    // JEQ taken
    run(16'h0000, 0, 0, 0, cyc);
    run(16'hEC10, 0, 0, 0, cyc);
    run(16'h0014, 0, 0, 0, cyc);
    run(16'hE302, 0, 0, 0, cyc);
    chk("jeq_taken", pc_dbg, 20);
    // JGT not taken on negative D
    run(16'hEE90, 0, 0, 0, cyc);
    chk("d_minus1", dut.d_r, 16'hFFFF);
    run(16'h0014, 0, 0, 0, cyc);
    run(16'hE301, 0, 0, 0, cyc);
    chk("jgt_not_taken", pc_dbg, 23);
    // A=D;JMP: target is the old A
    run(16'hE327, 0, 0, 0, cyc);
    chk("jmp_a_old", pc_dbg, 20);
    chk("jmp_a_new", dut.a_r, 16'hFFFF);

    // PC wrap at 0x7FFF
    run(16'h7FFF, 0, 0, 0, cyc);
    run(16'hEA87, 0, 0, 0, cyc);
    chk("jmp_7fff", pc_dbg, 15'h7FFF);
    run(16'hEA80, 0, 0, 0, cyc);
    chk("wrap_fetch_addr", f_addr, 15'h7FFF);
    chk("wrap_pc", pc_dbg, 0);

    // M read
    run(16'h0007, 0, 0, 0, cyc);
    run(16'hFC10, 0, 0, 16'h1234, cyc);
    chk("mrd_seen", {m_seen, m_wr}, 2'b10);
    chk("mrd_addr", m_addr, 7);
    chk("mrd_d", dut.d_r, 16'h1234);
    chk("mrd_cyc", cyc, 5);

    // Reset in the middle of an M read
    run(16'h0007, 0, 0, 0, cyc);
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'hFC10;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    for (int i = 0; i < 10 && !bus.dmem_rd; i++) @(negedge clk);
    chk("abort_rd_up", bus.dmem_rd, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_rd_drop", bus.dmem_rd, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_pc", pc_dbg, 0);
    chk("abort_d", dut.d_r, 0);
    repeat (3) @(negedge clk);
    chk("abort_no_retry", bus.dmem_rd, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
